serial_select_subtractor: RTL and testbench
===========================================

Name: serial_select_subtractor

Overview:
- Multi-cycle subtractor computing diff = a - b - bin over WIDTH-bit operands, SLICE bits per clock.
- Borrow ripples between cycles through a registered borrow flag.
- Within a slice, the difference is formed carry-select style: both borrow-in cases are precomputed and one is selected by the stored borrow.
- Serves as the arithmetic unit for wide subtract/compare operations where area matters more than latency; operands are accepted by a start/done handshake.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of SLICE (elaboration-time check, fatal otherwise).
- SLICE, 4, bits processed per RUN cycle.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  difference; holds until the next accepted start.
- bout  output  1  borrow-out of the MSB slice (1 = a < b + bin, unsigned).
- zero  output  1  diff == 0; valid with done and held with diff.

Behaviour:
- Single clock domain: clk. Reset: rst, synchronous, active-high.
- Reset value of every output: busy=0, done=0, diff=0, bout=0, zero=0. Internal state: state=IDLE, slice index=0, borrow register=0.
- N = WIDTH/SLICE; the slice index has ceil(log2(N)) bits, minimum 1.
- States:
  - IDLE: start=1 at an edge captures a, b and bin (borrow register <= bin), clears diff, sets idx=0, and goes to RUN.
  - RUN: each edge processes slice idx, LSB first. It computes d0 = a_s - b_s and d1 = a_s - b_s - 1, each with its own borrow. It selects by the borrow register, writes the selected SLICE bits into diff[idx*SLICE +: SLICE], updates the borrow register and increments idx. At idx == N-1 the state goes to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, with bout = final borrow and zero = (diff == 0). Next edge goes to IDLE unconditionally.
- Latency: start sampled at edge E; slices written at edges E+1 .. E+N; done visible in the cycle after edge E+N. With defaults, done is high in the cycle after edge E+4. Throughput is one operation per N+2 cycles.
- start while busy or in DONE is ignored: no capture and no effect on the in-flight operation.
- Inputs a, b and bin may change after acceptance without affecting the result.
- Arithmetic is unsigned modulo 2^WIDTH. bout is the true borrow. Example: 0 - 1 gives diff = all ones, bout = 1.
- rst asserted at any edge, including mid-RUN or in DONE, returns all state to reset values at that edge. done must not pulse for an aborted operation.
- rst and start high at the same edge: rst wins and nothing is captured.
- N = 1 is legal: RUN lasts one cycle.

Decomposition:
- Shared package (subtractor_pkg):
  - state enum {IDLE, RUN, DONE}, 2 bits.
  - default constants WIDTH=16, SLICE=4.
  - function computing the index width from N.
- One sub-module: slice_select_subtractor. It is purely combinational, parameterised by SLICE, with inputs a_s, b_s, borrow_in and outputs d, borrow_out. It builds both borrow cases internally and selects between them.
- The top level holds the FSM, operand registers, index, borrow register and result register.

Test Plan:
- Basic subtract: a=0x1234, b=0x0234, bin=0, start for 1 cycle. Require busy for 4 cycles, then done for 1 cycle with diff=0x1000, bout=0, zero=0.
- Underflow: a=0x0000, b=0x0001, bin=0. Require diff=0xFFFF, bout=1. Then a=0x8000, b=0x0000, bin=1: require diff=0x7FFF, bout=0.
- Equal operands: a=b=0xBEEF, bin=0. Require diff=0x0000, zero=1, bout=0. With bin=1, require diff=0xFFFF, bout=1, zero=0.
- Start during busy: issue a second start with different a and b at RUN cycle 2. Require the first result unchanged, only one done pulse, and the second request not processed.
- Reset mid-operation: assert rst at RUN cycle 2. The next cycle must show busy=0, done=0, diff=0, bout=0. No done pulse may follow. A fresh start must then complete correctly.
- Back-to-back and randomized: start issued in the IDLE cycle right after done is accepted (N+2-cycle spacing). Run 1000 random a, b, bin values against a reference model, for both WIDTH=16/SLICE=4 and WIDTH=8/SLICE=8.

Source files
------------

// File: rtl/serial_select_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : subtractor_pkg
// Description : Shared types, default sizes and helpers for the serial
//               carry-select subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package subtractor_pkg;

  // Controller states, explicitly 2 bits wide
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand width and slice width
  localparam int C_DEF_WIDTH = 16;
  localparam int C_DEF_SLICE = 4;

  // Width of the slice index for n slices: ceil(log2(n)), never below 1
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_select_subtractor_slice.sv
`default_nettype none
// ============================================================================
// Module      : slice_select_subtractor
// Description : Combinational SLICE-bit subtractor. Both borrow-in outcomes
//               are formed in parallel and the stored borrow picks one.
// Revision    : 1.0 - initial release
// ============================================================================
module slice_select_subtractor #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic             borrow_in,
  output logic [SLICE-1:0] d,
  output logic             borrow_out
);

  // One extra bit on each candidate holds its borrow (the sign of the result)
  logic [SLICE:0] w_d0;
  logic [SLICE:0] w_d1;

  // Borrow-in = 0 candidate: a_s - b_s
  assign w_d0 = {1'b0, a_s} - {1'b0, b_s};

  // Borrow-in = 1 candidate: a_s - b_s - 1
  assign w_d1 = {1'b0, a_s} - {1'b0, b_s} - {{SLICE{1'b0}}, 1'b1};

  // Select the candidate matching the incoming borrow
  assign d          = borrow_in ? w_d1[SLICE-1:0] : w_d0[SLICE-1:0];
  assign borrow_out = borrow_in ? w_d1[SLICE]     : w_d0[SLICE];

endmodule
`default_nettype wire

// File: rtl/serial_select_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_select_subtractor
// Description : Multi-cycle unsigned subtractor, diff = a - b - bin, handling
//               SLICE bits per clock LSB first with a registered borrow.
//               start/done handshake; result held until next accepted start.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_select_subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH = C_DEF_WIDTH,
  parameter int SLICE = C_DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int              N      = WIDTH / SLICE;
  localparam int              IW     = idx_width(N);
  localparam logic [IW-1:0]   C_LAST = IW'(N - 1);

  // Operand width must split evenly into slices
  if ((WIDTH % SLICE) != 0) begin : g_width_check
    $fatal(1, "serial_select_subtractor: WIDTH must be a multiple of SLICE");
  end

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_last;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [IW-1:0]      r_idx;
  logic               r_borrow;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic               r_zero;

  logic [SLICE-1:0]   w_a_s;
  logic [SLICE-1:0]   w_b_s;
  logic [SLICE-1:0]   w_d;
  logic               w_borrow_out;
  logic [WIDTH-1:0]   w_diff_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start only matters in IDLE
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_idx == C_LAST) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Pick the operand slice addressed by the index
  always_comb begin
    w_a_s = '0;
    w_b_s = '0;
    for (int i = 0; i < N; i++) begin
      if (r_idx == IW'(i)) begin
        w_a_s = r_a[i*SLICE +: SLICE];
        w_b_s = r_b[i*SLICE +: SLICE];
      end
    end
  end

  slice_select_subtractor #(
    .SLICE (SLICE)
  ) u_slice (
    .a_s        (w_a_s),
    .b_s        (w_b_s),
    .borrow_in  (r_borrow),
    .d          (w_d),
    .borrow_out (w_borrow_out)
  );

  // Result with the current slice merged in, so zero can see the final word
  always_comb begin
    w_diff_next = r_diff;
    for (int i = 0; i < N; i++) begin
      if (r_idx == IW'(i)) begin
        w_diff_next[i*SLICE +: SLICE] = w_d;
      end
    end
  end

  // Datapath: capture on accept, one slice per RUN cycle, flags on last slice
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= bin;
      r_idx    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
    end else if (r_state == RUN) begin
      r_diff   <= w_diff_next;
      r_borrow <= w_borrow_out;
      if (w_last) begin
        r_idx  <= '0;
        r_bout <= w_borrow_out;
        r_zero <= (w_diff_next == '0);
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign diff = r_diff;
  assign bout = r_bout;
  assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_select_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_select_subtractor
// Description : Directed and randomised checks of serial_select_subtractor
//               at WIDTH=16/SLICE=4 and WIDTH=8/SLICE=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_select_subtractor;

  logic        clk;
  logic        rst;

  logic        start16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        bin16;
  logic        busy16;
  logic        done16;
  logic [15:0] diff16;
  logic        bout16;
  logic        zero16;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        bin8;
  logic        busy8;
  logic        done8;
  logic [7:0]  diff8;
  logic        bout8;
  logic        zero8;

  int n_cmp;
  int n_err;

  serial_select_subtractor #(
    .WIDTH (16),
    .SLICE (4)
  ) dut16 (
    .clk   (clk),
    .rst   (rst),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .bin   (bin16),
    .busy  (busy16),
    .done  (done16),
    .diff  (diff16),
    .bout  (bout16),
    .zero  (zero16)
  );

  serial_select_subtractor #(
    .WIDTH (8),
    .SLICE (8)
  ) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8),
    .zero  (zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 16-bit operation from IDLE through DONE and back to IDLE
  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                      input logic [15:0] ediff, input logic eb, input logic ez);
    start16 = 1'b1;
    a16     = ta;
    b16     = tb;
    bin16   = tbin;
    step();
    start16 = 1'b0;
    a16     = 16'($urandom);
    b16     = 16'($urandom);
    bin16   = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      chk("busy16", busy16, 1);
      chk("done16_early", done16, 0);
      step();
    end
    chk("done16", done16, 1);
    chk("busy16_done", busy16, 0);
    chk("diff16", diff16, ediff);
    chk("bout16", bout16, eb);
    chk("zero16", zero16, ez);
    step();
    chk("done16_pulse", done16, 0);
    chk("diff16_hold", diff16, ediff);
  endtask

  // One 8-bit operation: single RUN cycle
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                     input logic [7:0] ediff, input logic eb, input logic ez);
    start8 = 1'b1;
    a8     = ta;
    b8     = tb;
    bin8   = tbin;
    step();
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    bin8   = 1'($urandom);
    chk("busy8", busy8, 1);
    chk("done8_early", done8, 0);
    step();
    chk("done8", done8, 1);
    chk("busy8_done", busy8, 0);
    chk("diff8", diff8, ediff);
    chk("bout8", bout8, eb);
    chk("zero8", zero8, ez);
    step();
    chk("done8_pulse", done8, 0);
  endtask

  initial begin
    logic [16:0] r16;
    logic [8:0]  r8;
    logic [15:0] ra16;
    logic [15:0] rb16;
    logic [7:0]  ra8;
    logic [7:0]  rb8;
    logic        rbin;

    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    start16 = 1'b0;
    a16     = '0;
    b16     = '0;
    bin16   = 1'b0;
    start8  = 1'b0;
    a8      = '0;
    b8      = '0;
    bin8    = 1'b0;
    repeat (3) step();

    chk("rst_busy", busy16, 0);
    chk("rst_done", done16, 0);
    chk("rst_diff", diff16, 0);
    chk("rst_bout", bout16, 0);
    chk("rst_zero", zero16, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_diff8", diff8, 0);
    rst = 1'b0;

    // Directed 16-bit vectors
    op16(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    op16(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    op16(16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b0);
    op16(16'hBEEF, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b1);
    op16(16'hBEEF, 16'hBEEF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Second start during RUN cycle 2 must be ignored
    start16 = 1'b1;
    a16     = 16'h5555;
    b16     = 16'h1111;
    bin16   = 1'b0;
    step();
    start16 = 1'b0;
    step();
    start16 = 1'b1;
    a16     = 16'h9999;
    b16     = 16'h1111;
    step();
    start16 = 1'b0;
    step();
    chk("ign_busy", busy16, 1);
    step();
    chk("ign_done", done16, 1);
    chk("ign_diff", diff16, 16'h4444);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ign_no_busy", busy16, 0);
      chk("ign_no_done", done16, 0);
    end
    chk("ign_diff_hold", diff16, 16'h4444);

    // Reset in RUN cycle 2 aborts without a done pulse
    start16 = 1'b1;
    a16     = 16'hFFFF;
    b16     = 16'h0000;
    bin16   = 1'b0;
    step();
    start16 = 1'b0;
    step();
    chk("lsb_first", diff16, 16'h000F);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy16, 0);
    chk("abort_done", done16, 0);
    chk("abort_diff", diff16, 0);
    chk("abort_bout", bout16, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_done", done16, 0);
      chk("abort_no_busy", busy16, 0);
    end
    op16(16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0);

    // Reset and start together: nothing captured
    rst     = 1'b1;
    start16 = 1'b1;
    a16     = 16'h1234;
    b16     = 16'h0001;
    step();
    rst     = 1'b0;
    start16 = 1'b0;
    chk("rst_start_busy", busy16, 0);
    step();
    chk("rst_start_busy2", busy16, 0);
    chk("rst_start_done", done16, 0);
    chk("rst_start_diff", diff16, 0);

    // Directed 8-bit vectors (single slice)
    op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    op8(8'h7F, 8'h7F, 1'b0, 8'h00, 1'b0, 1'b1);

    // Back-to-back random operations against a reference difference
    for (int k = 0; k < 1000; k++) begin
      ra16 = 16'($urandom);
      rb16 = 16'($urandom);
      rbin = 1'($urandom);
      if (k % 8 == 0) rb16 = ra16;
      r16  = {1'b0, ra16} - {1'b0, rb16} - {16'd0, rbin};
      op16(ra16, rb16, rbin, r16[15:0], r16[16], (r16[15:0] == 16'd0));
    end
    for (int k = 0; k < 1000; k++) begin
      ra8  = 8'($urandom);
      rb8  = 8'($urandom);
      rbin = 1'($urandom);
      if (k % 8 == 0) rb8 = ra8;
      r8   = {1'b0, ra8} - {1'b0, rb8} - {8'd0, rbin};
      op8(ra8, rb8, rbin, r8[7:0], r8[8], (r8[7:0] == 8'd0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Run-time bound
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
